// File: rtl/tft_ctrl.sv
// ----------------------------------------------------------------------------
// tft_ctrl : timing controller for an 800x480 TFT panel on the pixel clock.
//
// Generates hsync/vsync/tft_de/tft_bl from a free-running line/frame counter,
// issues pixel-coordinate requests one clock ahead of data-enable to a
// registered pixel generator, and passes the returned colour to the panel
// while tft_de is high. Display on/off requests are honoured only in the last
// cycle of a frame, so the panel always sees whole frames.
//
// Ports
//   tft_clk      in   pixel clock, single domain
//   sys_rst_n    in   asynchronous active-low reset
//   disp_en      in   display enable request (level, sampled at frame end)
//   pix_data     in   [23:0] RGB888 for the coordinate requested last clock
//   pix_x        out  [10:0] requested X, 11'h3FF outside the request window
//   pix_y        out  [10:0] requested Y, 11'h3FF outside the request window
//   rgb_tft      out  [23:0] panel colour, zero whenever tft_de is low
//   hsync        out  horizontal sync, active high
//   vsync        out  vertical sync, active high
//   tft_de       out  panel data enable
//   tft_bl       out  backlight enable
//   frame_start  out  one-clock pulse at line 0, clock 0
//
// Display state
//   state | meaning
//   ------+-------------------------------------------------------------
//   OFF   | no requests, tft_de and tft_bl held low; syncs keep running
//   ON    | requests and tft_de in the active area, backlight on
// ----------------------------------------------------------------------------
module tft_ctrl #(
   parameter logic [10:0] H_SYNC  = 11'd1,
   parameter logic [10:0] H_BACK  = 11'd46,
   parameter logic [10:0] H_VALID = 11'd800,
   parameter logic [10:0] H_FRONT = 11'd210,
   parameter logic [10:0] H_TOTAL = 11'd1057,
   parameter logic [10:0] V_SYNC  = 11'd1,
   parameter logic [10:0] V_BACK  = 11'd23,
   parameter logic [10:0] V_VALID = 11'd480,
   parameter logic [10:0] V_FRONT = 11'd22,
   parameter logic [10:0] V_TOTAL = 11'd526
) (
   input  logic        tft_clk,
   input  logic        sys_rst_n,
   input  logic        disp_en,
   input  logic [23:0] pix_data,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic [23:0] rgb_tft,
   output logic        hsync,
   output logic        vsync,
   output logic        tft_de,
   output logic        tft_bl,
   output logic        frame_start
);

   typedef enum logic {OFF = 1'b0, ON = 1'b1} disp_state_t;

   // Requests lead tft_de by one clock to cover the generator's register.
   localparam logic [10:0] H_REQ_BEG = H_SYNC + H_BACK - 11'd1;
   localparam logic [10:0] H_REQ_END = H_SYNC + H_BACK + H_VALID - 11'd1;
   localparam logic [10:0] H_DE_BEG  = H_SYNC + H_BACK;
   localparam logic [10:0] H_DE_END  = H_SYNC + H_BACK + H_VALID;
   localparam logic [10:0] V_ACT_BEG = V_SYNC + V_BACK;
   localparam logic [10:0] V_ACT_END = V_SYNC + V_BACK + V_VALID;

   // An inconsistent parameter set keeps the display dark rather than
   // driving a malformed active area onto the panel.
   localparam logic TIMING_OK =
      (H_TOTAL == H_SYNC + H_BACK + H_VALID + H_FRONT) &&
      (V_TOTAL == V_SYNC + V_BACK + V_VALID + V_FRONT);

   logic [10:0] cnt_h;
   logic [10:0] cnt_v;
   logic        h_last;
   logic        v_last;
   logic        v_act;
   logic        req_win;

   disp_state_t state_q;
   disp_state_t state_d;

   assign h_last = (cnt_h == H_TOTAL - 11'd1);
   assign v_last = (cnt_v == V_TOTAL - 11'd1);

   always_ff @(posedge tft_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_h <= '0;
         cnt_v <= '0;
      end else if (h_last) begin
         cnt_h <= '0;
         cnt_v <= v_last ? 11'd0 : cnt_v + 11'd1;
      end else begin
         cnt_h <= cnt_h + 11'd1;
      end
   end

   always_ff @(posedge tft_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= OFF;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (h_last && v_last) begin
         state_d = (disp_en && TIMING_OK) ? ON : OFF;
      end
   end

   assign v_act   = (cnt_v >= V_ACT_BEG) && (cnt_v < V_ACT_END);
   assign req_win = (state_q == ON) && v_act &&
                    (cnt_h >= H_REQ_BEG) && (cnt_h < H_REQ_END);

   assign pix_x = req_win ? (cnt_h - H_REQ_BEG) : 11'h3FF;
   assign pix_y = req_win ? (cnt_v - V_ACT_BEG) : 11'h3FF;

   assign tft_de = (state_q == ON) && v_act &&
                   (cnt_h >= H_DE_BEG) && (cnt_h < H_DE_END);

   assign rgb_tft     = tft_de ? pix_data : 24'h000000;
   assign hsync       = (cnt_h < H_SYNC);
   assign vsync       = (cnt_v < V_SYNC);
   assign tft_bl      = (state_q == ON);
   assign frame_start = (cnt_h == 11'd0) && (cnt_v == 11'd0);

endmodule

// File: tb/tb_tft_ctrl.sv
module tb_tft_ctrl;

   localparam int HS = 1, HB = 3, HV = 8, HF = 4, HT = HS + HB + HV + HF;
   localparam int VS = 1, VB = 2, VV = 4, VF = 2, VT = VS + VB + VV + VF;
   localparam int FRAME = HT * VT;

   logic        tft_clk;
   logic        sys_rst_n;
   logic        disp_en;
   logic [23:0] pix_data;
   logic [10:0] pix_x, pix_y;
   logic [23:0] rgb_tft;
   logic        hsync, vsync, tft_de, tft_bl, frame_start;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [23:0] sb_q[$];

   tft_ctrl #(
      .H_SYNC(11'(HS)), .H_BACK(11'(HB)), .H_VALID(11'(HV)),
      .H_FRONT(11'(HF)), .H_TOTAL(11'(HT)),
      .V_SYNC(11'(VS)), .V_BACK(11'(VB)), .V_VALID(11'(VV)),
      .V_FRONT(11'(VF)), .V_TOTAL(11'(VT))
   ) dut (
      .tft_clk(tft_clk), .sys_rst_n(sys_rst_n), .disp_en(disp_en),
      .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .rgb_tft(rgb_tft),
      .hsync(hsync), .vsync(vsync), .tft_de(tft_de), .tft_bl(tft_bl),
      .frame_start(frame_start)
   );

   initial tft_clk = 1'b0;
   always #5 tft_clk = ~tft_clk;

   // Clocks since reset release: equals the expected cnt_v*HT+cnt_h modulo FRAME.
   always @(posedge tft_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) cyc <= 0;
      else            cyc <= cyc + 1;
   end

   // Registered pixel generator; nonzero filler outside requests.
   always @(posedge tft_clk)
      pix_data <= (pix_x !== 11'h3FF) ? {2'b00, pix_x, pix_y} : 24'h5A5A5A;

   function automatic int hof(int c); return c % HT; endfunction
   function automatic int vof(int c); return (c / HT) % VT; endfunction
   function automatic bit v_act(int c);
      return (vof(c) >= VS + VB) && (vof(c) < VS + VB + VV);
   endfunction
   function automatic bit req_win(int c);
      return v_act(c) && (hof(c) >= HS + HB - 1) && (hof(c) < HS + HB + HV - 1);
   endfunction
   function automatic bit de_win(int c);
      return v_act(c) && (hof(c) >= HS + HB) && (hof(c) < HS + HB + HV);
   endfunction

   task automatic wait_frame_end();
      int n = 0;
      while ((cyc % FRAME != FRAME - 1) && n <= FRAME) begin
         @(negedge tft_clk);
         n++;
      end
      if (n > FRAME) begin
         total++; bad++;
         $display("FAIL wait_frame_end timeout cyc=%0d", cyc);
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      disp_en   = 1'b0;
      #1;
      total++;
      if ({hsync, vsync, frame_start, tft_de, tft_bl} !== 5'b11100) begin
         bad++; $display("FAIL reset_ctrl got=%b want=11100",
                         {hsync, vsync, frame_start, tft_de, tft_bl});
      end
      total++;
      if (rgb_tft !== 24'h0 || pix_x !== 11'h3FF || pix_y !== 11'h3FF) begin
         bad++; $display("FAIL reset_data rgb=%h x=%h y=%h want 0/3ff/3ff",
                         rgb_tft, pix_x, pix_y);
      end
      repeat (3) @(negedge tft_clk);
      sys_rst_n = 1'b1;
      total++;
      if (frame_start !== 1'b1 || tft_bl !== 1'b0) begin
         bad++; $display("FAIL reset_release fs=%b bl=%b want 1/0", frame_start, tft_bl);
      end
   endtask

   task automatic test_idle();
      int c, last_hs = 0, last_vs = 0, hs_rises = 0, vs_rises = 0;
      logic prev_hs = 1'b1, prev_vs = 1'b1;
      repeat (2 * FRAME) begin
         @(negedge tft_clk);
         c = cyc;
         if (hsync === 1'b1 && prev_hs === 1'b0) begin
            hs_rises++; total++;
            if (c - last_hs != HT) begin
               bad++; $display("FAIL hsync_period got=%0d want=%0d", c - last_hs, HT);
            end
            last_hs = c;
         end
         if (vsync === 1'b1 && prev_vs === 1'b0) begin
            vs_rises++; total++;
            if (c - last_vs != FRAME) begin
               bad++; $display("FAIL vsync_period got=%0d want=%0d", c - last_vs, FRAME);
            end
            last_vs = c;
         end
         if (vsync === 1'b0 && prev_vs === 1'b1) begin
            total++;
            if (c - last_vs != VS * HT) begin
               bad++; $display("FAIL vsync_width got=%0d want=%0d", c - last_vs, VS * HT);
            end
         end
         total++;
         if (hsync !== (hof(c) < HS) || vsync !== (vof(c) < VS)) begin
            bad++; $display("FAIL sync_level c=%0d hs=%b vs=%b", c, hsync, vsync);
         end
         total++;
         if (tft_de !== 1'b0 || tft_bl !== 1'b0 || pix_x !== 11'h3FF) begin
            bad++; $display("FAIL idle_gate c=%0d de=%b bl=%b x=%h want 0/0/3ff",
                            c, tft_de, tft_bl, pix_x);
         end
         prev_hs = hsync;
         prev_vs = vsync;
      end
      total++;
      if (hs_rises != 2 * VT || vs_rises != 2) begin
         bad++; $display("FAIL sync_counts hs=%0d vs=%0d want %0d/2", hs_rises, vs_rises, 2 * VT);
      end
   endtask

   task automatic test_enable_gating();
      int c, first_req = -1, first_de = -1;
      repeat (FRAME / 2) @(negedge tft_clk);
      disp_en = 1'b1;
      while (cyc % FRAME != FRAME - 1) begin
         @(negedge tft_clk);
         total++;
         if (tft_bl !== 1'b0 || tft_de !== 1'b0) begin
            bad++; $display("FAIL bl_early c=%0d bl=%b de=%b want 0/0", cyc, tft_bl, tft_de);
         end
      end
      @(negedge tft_clk);
      total++;
      if (tft_bl !== 1'b1 || frame_start !== 1'b1) begin
         bad++; $display("FAIL bl_on bl=%b fs=%b want 1/1", tft_bl, frame_start);
      end
      for (int i = 0; i < FRAME && first_de < 0; i++) begin
         @(negedge tft_clk);
         c = cyc;
         if (first_req < 0 && pix_x !== 11'h3FF) begin
            first_req = c;
            total++;
            if (pix_x !== 11'd0 || pix_y !== 11'd0) begin
               bad++; $display("FAIL first_pix x=%0d y=%0d want 0/0", pix_x, pix_y);
            end
         end
         if (tft_de === 1'b1) first_de = c;
      end
      total++;
      if (first_req < 0 || hof(first_req) != HS + HB - 1 || vof(first_req) != VS + VB) begin
         bad++; $display("FAIL first_req_pos c=%0d want h=%0d v=%0d", first_req, HS + HB - 1, VS + VB);
      end
      total++;
      if (first_de < 0 || first_de != first_req + 1) begin
         bad++; $display("FAIL first_de_pos got=%0d want=%0d", first_de, first_req + 1);
      end
   endtask

   task automatic test_pixel_alignment();
      int c, h, v, line_de = 0, tot_de = 0, lines = 0;
      logic [10:0] ex_x, ex_y;
      logic [23:0] ex;
      wait_frame_end();
      sb_q.delete();
      repeat (FRAME) begin
         @(negedge tft_clk);
         c = cyc; h = hof(c); v = vof(c);
         if (de_win(c)) begin
            total++;
            if (tft_de !== 1'b1) begin
               bad++; $display("FAIL de_on h=%0d v=%0d de=%b", h, v, tft_de);
            end
            total++;
            if (sb_q.size() == 0) begin
               bad++; $display("FAIL sb_empty h=%0d v=%0d", h, v);
            end else begin
               ex = sb_q.pop_front();
               if (rgb_tft !== ex) begin
                  bad++; $display("FAIL rgb h=%0d v=%0d got=%h want=%h", h, v, rgb_tft, ex);
               end
            end
         end else begin
            total++;
            if (tft_de !== 1'b0 || rgb_tft !== 24'h0) begin
               bad++; $display("FAIL de_off h=%0d v=%0d de=%b rgb=%h pd=%h",
                               h, v, tft_de, rgb_tft, pix_data);
            end
         end
         if (tft_de === 1'b1) line_de++;
         total++;
         if (req_win(c)) begin
            ex_x = 11'(h - (HS + HB - 1));
            ex_y = 11'(v - (VS + VB));
            if (pix_x !== ex_x || pix_y !== ex_y) begin
               bad++; $display("FAIL req h=%0d v=%0d got=%0d/%0d want=%0d/%0d",
                               h, v, pix_x, pix_y, ex_x, ex_y);
            end
            sb_q.push_back({2'b00, ex_x, ex_y});
         end else if (pix_x !== 11'h3FF || pix_y !== 11'h3FF) begin
            bad++; $display("FAIL req_off h=%0d v=%0d got=%h/%h want 3ff", h, v, pix_x, pix_y);
         end
         total++;
         if (frame_start !== (h == 0 && v == 0) || tft_bl !== 1'b1) begin
            bad++; $display("FAIL fs_bl h=%0d v=%0d fs=%b bl=%b", h, v, frame_start, tft_bl);
         end
         if (h == HT - 1) begin
            if (line_de > 0) begin
               lines++; total++;
               if (line_de != HV) begin
                  bad++; $display("FAIL line_count v=%0d got=%0d want=%0d", v, line_de, HV);
               end
            end
            tot_de += line_de;
            line_de = 0;
         end
      end
      total++;
      if (tot_de != HV * VV || lines != VV || sb_q.size() != 0) begin
         bad++; $display("FAIL frame_count de=%0d lines=%0d left=%0d want %0d/%0d/0",
                         tot_de, lines, sb_q.size(), HV * VV, VV);
      end
   endtask

   task automatic test_disable_gating();
      int c, tot_de = 0, lines = 0, line_de = 0;
      wait_frame_end();
      repeat (FRAME) begin
         @(negedge tft_clk);
         c = cyc;
         if (tft_de === 1'b1) line_de++;
         if (hof(c) == HT - 1) begin
            if (line_de > 0) lines++;
            tot_de += line_de;
            line_de = 0;
         end
         if (vof(c) == VS + VB + 1 && hof(c) == 0) disp_en = 1'b0;
      end
      total++;
      if (tot_de != HV * VV || lines != VV) begin
         bad++; $display("FAIL disable_frame de=%0d lines=%0d want %0d/%0d", tot_de, lines, HV * VV, VV);
      end
      repeat (FRAME) begin
         @(negedge tft_clk);
         c = cyc;
         total++;
         if (tft_de !== 1'b0 || tft_bl !== 1'b0 || pix_x !== 11'h3FF) begin
            bad++; $display("FAIL off_frame h=%0d v=%0d de=%b bl=%b x=%h",
                            hof(c), vof(c), tft_de, tft_bl, pix_x);
         end
         if (hof(c) == 0 && vof(c) == VT / 2) disp_en = 1'b1;
      end
   endtask

   task automatic test_mid_reset();
      int n = 0;
      while (!(hof(cyc) == HS + HB + 2 && vof(cyc) == VS + VB + 1) && n <= FRAME) begin
         @(negedge tft_clk);
         n++;
      end
      total++;
      if (n > FRAME || tft_de !== 1'b1 || tft_bl !== 1'b1) begin
         bad++; $display("FAIL pre_reset n=%0d de=%b bl=%b want 1/1", n, tft_de, tft_bl);
      end
      sys_rst_n = 1'b0;
      #1;
      total++;
      if ({hsync, vsync, frame_start, tft_de, tft_bl} !== 5'b11100 ||
          rgb_tft !== 24'h0 || pix_x !== 11'h3FF || pix_y !== 11'h3FF) begin
         bad++; $display("FAIL async_reset ctrl=%b rgb=%h x=%h y=%h",
                         {hsync, vsync, frame_start, tft_de, tft_bl}, rgb_tft, pix_x, pix_y);
      end
      repeat (2) @(negedge tft_clk);
      sys_rst_n = 1'b1;
      total++;
      if (frame_start !== 1'b1 || tft_bl !== 1'b0) begin
         bad++; $display("FAIL post_reset fs=%b bl=%b want 1/0", frame_start, tft_bl);
      end
      repeat (FRAME - 1) begin
         @(negedge tft_clk);
         total++;
         if (tft_bl !== 1'b0 || tft_de !== 1'b0 || frame_start !== 1'b0) begin
            bad++; $display("FAIL post_reset_off c=%0d bl=%b de=%b fs=%b",
                            cyc, tft_bl, tft_de, frame_start);
         end
      end
   endtask

   initial begin
      sys_rst_n = 1'b0;
      disp_en   = 1'b0;
      test_reset();
      test_idle();
      test_enable_gating();
      test_pixel_alignment();
      test_disable_gating();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tft_ctrl.md
# tft_ctrl

Timing controller for the 800x480 TFT panel, running on the pixel clock. It generates the horizontal/vertical sync, data-enable and backlight signals, and issues pixel-coordinate requests one cycle ahead to the pixel-generation block (registered, 1-cycle latency). It returns that block's colour data to the panel, aligned to data-enable. Display on/off requests take effect only at frame boundaries, so the panel never sees a partial frame.

## Interface
Parameters:
- H_SYNC, 11'd1, hsync pulse width (clocks)
- H_BACK, 11'd46, horizontal back porch
- H_VALID, 11'd800, active pixels per line
- H_FRONT, 11'd210, horizontal front porch
- H_TOTAL, 11'd1057, line length = sum of the above
- V_SYNC, 11'd1, vsync pulse width (lines)
- V_BACK, 11'd23, vertical back porch
- V_VALID, 11'd480, active lines
- V_FRONT, 11'd22, vertical front porch
- V_TOTAL, 11'd526, frame length in lines

Ports:
- tft_clk, in, 1, pixel clock (33.3 MHz); single clock domain
- sys_rst_n, in, 1, asynchronous active-low reset
- disp_en, in, 1, display enable request; level, sampled only at the frame boundary
- pix_data, in, 24, RGB888 from the pixel generator; corresponds to the pix_x/pix_y presented one cycle earlier
- pix_x, out, 11, requested X coordinate 0..799; 11'h3FF outside the request window
- pix_y, out, 11, requested Y coordinate 0..479; 11'h3FF outside the request window
- rgb_tft, out, 24, panel colour data; 24'h000000 whenever tft_de=0
- hsync, out, 1, horizontal sync, active high
- vsync, out, 1, vertical sync, active high
- tft_de, out, 1, panel data enable
- tft_bl, out, 1, backlight enable
- frame_start, out, 1, one-cycle pulse at line 0, clock 0 of each frame

## Operation
- cnt_h: 11-bit register, counts 0..H_TOTAL-1 and wraps to 0.
- cnt_v: 11-bit register, increments when cnt_h==H_TOTAL-1; wraps to 0 after V_TOTAL-1.
- Sync outputs:
  - hsync = (cnt_h < H_SYNC); vsync = (cnt_v < V_SYNC).
  - Syncs always run, independent of disp_active.
- Display state (disp_active register):
  - States: OFF (0) and ON (1).
  - Transition happens only in the boundary cycle (cnt_h==H_TOTAL-1 && cnt_v==V_TOTAL-1): disp_active <= disp_en.
  - disp_en changes at any other time have no effect.
- Request window: disp_active && cnt_v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID) && cnt_h in [H_SYNC+H_BACK-1, H_SYNC+H_BACK+H_VALID-1).
  - Inside the window: pix_x = cnt_h-(H_SYNC+H_BACK-1); pix_y = cnt_v-(V_SYNC+V_BACK).
  - Outside the window: both are 11'h3FF.
- tft_de: same as the request window shifted one clock later, i.e. cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID), same vertical range, gated by disp_active.
- rgb_tft = tft_de ? pix_data : 24'h000000.
- tft_bl = disp_active.
- frame_start = (cnt_h==0 && cnt_v==0).
- Outputs are combinational decodes of the registered cnt_h, cnt_v and disp_active; none depends combinationally on disp_en.

## Timing
- Reset values (sys_rst_n low, asynchronous): cnt_h=0, cnt_v=0, disp_active=0. Resulting outputs: hsync=1, vsync=1, frame_start=1, tft_de=0, tft_bl=0, rgb_tft=0, pix_x=pix_y=11'h3FF.
- Reset mid-frame: all outputs return to reset values immediately. After release, counting restarts from 0 with display OFF.
- Periods:
  - Line: 1057 clocks.
  - Frame: 1057*526 = 555,982 clocks.
  - Active pixels per line: 800; per frame: 384,000.
- With default parameters:
  - Requests: cnt_h 46..845, cnt_v 24..503.
  - tft_de: cnt_h 47..846, same lines.
- Pipeline latency: request to rgb_tft is exactly 1 clock. The pixel requested at pix_x=k appears on rgb_tft when cnt_h=47+k.
- disp_en latency: a value sampled in the boundary cycle governs the whole next frame; tft_bl changes on the first clock of that frame.
- disp_en toggling mid-frame, or glitching outside the boundary cycle: ignored.

## Test plan
- **Idle after reset:** release reset with disp_en=0, run 2 frames.
  - hsync period 1057 clocks; vsync period 555,982 clocks with 1057-clock width.
  - tft_de never 1; pix_x=11'h3FF throughout; tft_bl=0.
- **Enable gating:** raise disp_en mid-frame 0.
  - tft_bl=0 until the clock after the boundary cycle.
  - First pix_x=0/pix_y=0 at cnt_v=24, cnt_h=46 of frame 1; first tft_de at cnt_h=47.
- **Pixel alignment:** model the generator as pix_data <= {2'b0, pix_x, pix_y} registered.
  - Every tft_de cycle: rgb_tft[21:11] = cnt_h-47 and rgb_tft[10:0] = cnt_v-24.
  - rgb_tft=0 whenever tft_de=0, even when pix_data is forced nonzero.
- **Counts:** with the display ON, each active line has exactly 800 tft_de clocks; each frame has exactly 384,000 tft_de clocks and 480 active lines.
- **Disable gating:** drop disp_en at line 100 of an ON frame.
  - That frame still completes all 480 active lines.
  - The next frame has tft_de=0 and tft_bl=0 from its first clock.
- **Mid-operation reset:** assert sys_rst_n low at cnt_h=500, cnt_v=300 of an ON frame.
  - Outputs take reset values without waiting for a clock edge.
  - After release: frame_start=1 on the first clock, display OFF.
